// File: rtl/fetch_pkg.sv
// Shared types and default constants for the MIPS instruction-fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        BUF   = 2'd1,
        DROP  = 2'd2
    } fetch_state_t;

    localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register: flush (bubble) beats load, load beats hold.
module ifid_reg
    import fetch_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        flush,
    input  logic        next_valid,
    input  logic [31:0] next_instr,
    input  logic [31:0] next_pc_plus4,
    output logic        valid,
    output logic [31:0] instr,
    output logic [31:0] pc_plus4
);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            valid    <= 1'b0;
            instr    <= NOP_INSTR;
            pc_plus4 <= '0;
        end else if (load) begin
            valid    <= next_valid;
            instr    <= next_instr;
            pc_plus4 <= next_pc_plus4;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC, instruction-memory handshake, one-entry fetch buffer, IF/ID register.
// Optional macro FETCH_PERF_EN adds stall and dropped-ack performance counters.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        pc_write_i,
    input  logic        ifid_hold_i,
    input  logic        if_flush_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    output logic [31:0] pc_o,
    output logic        ifid_valid_o,
    output logic [31:0] ifid_instr_o,
    output logic [31:0] ifid_pc_plus4_o
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_stall_cnt_o,
    output logic [31:0] perf_drop_cnt_o
`endif
);

    fetch_state_t state, state_next;
    logic [31:0]  pc, pc_next;
    logic [31:0]  drop_addr, drop_addr_next;
    logic [31:0]  buf_data, buf_data_next;
    logic [31:0]  pc_plus4;
    logic [31:0]  redirect_pc;
    logic         advance;
    logic         ifid_load;
    logic         ifid_next_valid;
    logic [31:0]  ifid_next_instr;
    logic [31:0]  ifid_next_pc_plus4;

    assign advance     = pc_write_i & ~ifid_hold_i;
    assign pc_plus4    = pc + 32'd4;
    assign redirect_pc = branch_target_i & 32'hFFFF_FFFC;

    // A request abandoned by a redirect keeps its original address until acked.
    assign imem_req_o  = (state != BUF) & ~rst_i;
    assign imem_addr_o = (state == DROP) ? drop_addr : pc;
    assign pc_o        = pc;

    always_comb begin
        state_next         = state;
        pc_next            = pc;
        drop_addr_next     = drop_addr;
        buf_data_next      = buf_data;
        ifid_load          = 1'b0;
        ifid_next_valid    = 1'b0;
        ifid_next_instr    = NOP_INSTR;
        ifid_next_pc_plus4 = '0;

        unique case (state)
            FETCH: begin
                if (branch_taken_i) begin
                    pc_next   = redirect_pc;
                    ifid_load = advance;
                    if (!imem_ack_i) begin
                        state_next     = DROP;
                        drop_addr_next = pc;
                    end
                end else if (imem_ack_i) begin
                    if (advance) begin
                        ifid_load          = 1'b1;
                        ifid_next_valid    = 1'b1;
                        ifid_next_instr    = imem_data_i;
                        ifid_next_pc_plus4 = pc_plus4;
                        pc_next            = pc_plus4;
                    end else begin
                        buf_data_next = imem_data_i;
                        state_next    = BUF;
                    end
                end else begin
                    ifid_load = advance;
                end
            end
            BUF: begin
                if (branch_taken_i) begin
                    pc_next       = redirect_pc;
                    buf_data_next = NOP_INSTR;
                    ifid_load     = advance;
                    state_next    = FETCH;
                end else if (advance) begin
                    ifid_load          = 1'b1;
                    ifid_next_valid    = 1'b1;
                    ifid_next_instr    = buf_data;
                    ifid_next_pc_plus4 = pc_plus4;
                    pc_next            = pc_plus4;
                    buf_data_next      = NOP_INSTR;
                    state_next         = FETCH;
                end
            end
            DROP: begin
                ifid_load = advance;
                if (branch_taken_i) begin
                    pc_next = redirect_pc;
                end
                if (imem_ack_i) begin
                    state_next = FETCH;
                end
            end
            default: begin
                state_next = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            drop_addr <= RESET_PC;
            buf_data  <= NOP_INSTR;
        end else begin
            state     <= state_next;
            pc        <= pc_next;
            drop_addr <= drop_addr_next;
            buf_data  <= buf_data_next;
        end
    end

    ifid_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_ifid_reg (
        .clk           (clk_i),
        .rst           (rst_i),
        .load          (ifid_load),
        .flush         (if_flush_i),
        .next_valid    (ifid_next_valid),
        .next_instr    (ifid_next_instr),
        .next_pc_plus4 (ifid_next_pc_plus4),
        .valid         (ifid_valid_o),
        .instr         (ifid_instr_o),
        .pc_plus4      (ifid_pc_plus4_o)
    );

`ifdef FETCH_PERF_EN
    logic        ack_dropped;
    logic [31:0] stall_cnt;
    logic [31:0] drop_cnt;

    assign ack_dropped = imem_ack_i &
                         (((state == FETCH) & branch_taken_i) | (state == DROP));

    // Both counters saturate rather than wrap.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt <= '0;
            drop_cnt  <= '0;
        end else begin
            if (!advance && (stall_cnt != 32'hFFFF_FFFF)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (ack_dropped && (drop_cnt != 32'hFFFF_FFFF)) begin
                drop_cnt <= drop_cnt + 32'd1;
            end
        end
    end

    assign perf_stall_cnt_o = stall_cnt;
    assign perf_drop_cnt_o  = drop_cnt;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized run checked
// against an architectural in-order instruction-stream model.
`timescale 1ns/1ps
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0000;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        pc_write_i;
    logic        ifid_hold_i;
    logic        if_flush_i;
    logic        branch_taken_i;
    logic [31:0] branch_target_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_data_i;
    logic [31:0] pc_o;
    logic        ifid_valid_o;
    logic [31:0] ifid_instr_o;
    logic [31:0] ifid_pc_plus4_o;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_stall_cnt_o;
    logic [31:0] perf_drop_cnt_o;
`endif

    int n_compared   = 0;
    int n_mismatched = 0;

    always #5 clk_i = ~clk_i;

    fetch_stage #(
        .RESET_PC  (RST_PC),
        .NOP_INSTR (NOP)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .pc_write_i      (pc_write_i),
        .ifid_hold_i     (ifid_hold_i),
        .if_flush_i      (if_flush_i),
        .branch_taken_i  (branch_taken_i),
        .branch_target_i (branch_target_i),
        .imem_req_o      (imem_req_o),
        .imem_addr_o     (imem_addr_o),
        .imem_ack_i      (imem_ack_i),
        .imem_data_i     (imem_data_i),
        .pc_o            (pc_o),
        .ifid_valid_o    (ifid_valid_o),
        .ifid_instr_o    (ifid_instr_o),
        .ifid_pc_plus4_o (ifid_pc_plus4_o)
`ifdef FETCH_PERF_EN
        ,
        .perf_stall_cnt_o (perf_stall_cnt_o),
        .perf_drop_cnt_o  (perf_drop_cnt_o)
`endif
    );

    // Instruction memory contents: a distinct word for every address.
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return {addr[15:0], addr[31:16]} ^ 32'hC3A5_5A3C;
    endfunction

    task automatic set_idle();
        pc_write_i      = 1'b1;
        ifid_hold_i     = 1'b0;
        if_flush_i      = 1'b0;
        branch_taken_i  = 1'b0;
        branch_target_i = '0;
        imem_ack_i      = 1'b0;
        imem_data_i     = '0;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        set_idle();
        tick();
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        n_compared++;
        if ({imem_req_o, pc_o} !== {1'b0, RST_PC}) begin
            n_mismatched++;
            $display("[TB] FAIL reset_req_pc: got req=%b pc=%h expected req=0 pc=%h", imem_req_o, pc_o, RST_PC);
        end
        n_compared++;
        if ({ifid_valid_o, ifid_instr_o, ifid_pc_plus4_o} !== {1'b0, NOP, 32'h0}) begin
            n_mismatched++;
            $display("[TB] FAIL reset_ifid: got %b/%h/%h expected 0/%h/0", ifid_valid_o, ifid_instr_o, ifid_pc_plus4_o, NOP);
        end
`ifdef FETCH_PERF_EN
        n_compared++;
        if ({perf_stall_cnt_o, perf_drop_cnt_o} !== 64'h0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_perf: got %h/%h expected 0/0", perf_stall_cnt_o, perf_drop_cnt_o);
        end
`endif
        rst_i = 1'b0;
        #1;
        n_compared++;
        if ({imem_req_o, imem_addr_o} !== {1'b1, RST_PC}) begin
            n_mismatched++;
            $display("[TB] FAIL first_request: got req=%b addr=%h expected req=1 addr=%h", imem_req_o, imem_addr_o, RST_PC);
        end
    endtask

    task automatic test_zero_wait();
        logic [31:0] a;
        do_reset();
        rst_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a = RST_PC + 32'(4 * i);
            #1;
            n_compared++;
            if ({imem_req_o, imem_addr_o} !== {1'b1, a}) begin
                n_mismatched++;
                $display("[TB] FAIL zero_wait_addr[%0d]: got req=%b addr=%h expected req=1 addr=%h", i, imem_req_o, imem_addr_o, a);
            end
            imem_ack_i  = 1'b1;
            imem_data_i = mem_word(a);
            tick();
            n_compared++;
            if ({ifid_valid_o, ifid_instr_o, ifid_pc_plus4_o} !== {1'b1, mem_word(a), a + 32'd4}) begin
                n_mismatched++;
                $display("[TB] FAIL zero_wait_ifid[%0d]: got %b/%h/%h expected 1/%h/%h", i, ifid_valid_o, ifid_instr_o, ifid_pc_plus4_o, mem_word(a), a + 32'd4);
            end
        end
        set_idle();
    endtask

    task automatic test_stall_buffer();
        do_reset();
        rst_i       = 1'b0;
        imem_ack_i  = 1'b1;
        imem_data_i = mem_word(32'h0);
        tick();
        imem_ack_i  = 1'b0;
        pc_write_i  = 1'b0;
        ifid_hold_i = 1'b1;
        tick();
        tick();
        imem_ack_i  = 1'b1;
        imem_data_i = 32'h8C22_0004;
        tick();
        imem_ack_i  = 1'b0;
        n_compared++;
        if ({imem_req_o, pc_o, ifid_valid_o, ifid_instr_o, ifid_pc_plus4_o} !== {1'b0, 32'h4, 1'b1, mem_word(32'h0), 32'h4}) begin
            n_mismatched++;
            $display("[TB] FAIL stall_buffer_hold: got req=%b pc=%h ifid=%b/%h/%h expected req=0 pc=4 ifid=1/%h/4", imem_req_o, pc_o, ifid_valid_o, ifid_instr_o, ifid_pc_plus4_o, mem_word(32'h0));
        end
        tick();
        n_compared++;
        if (imem_req_o !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL stall_buffer_req: got req=%b expected req=0", imem_req_o);
        end
        pc_write_i  = 1'b1;
        ifid_hold_i = 1'b0;
        tick();
        n_compared++;
        if ({ifid_valid_o, ifid_instr_o, ifid_pc_plus4_o, pc_o} !== {1'b1, 32'h8C22_0004, 32'h8, 32'h8}) begin
            n_mismatched++;
            $display("[TB] FAIL stall_buffer_release: got ifid=%b/%h/%h pc=%h expected 1/8c220004/8 pc=8", ifid_valid_o, ifid_instr_o, ifid_pc_plus4_o, pc_o);
        end
        n_compared++;
        if ({imem_req_o, imem_addr_o} !== {1'b1, 32'h8}) begin
            n_mismatched++;
            $display("[TB] FAIL stall_buffer_next_req: got req=%b addr=%h expected req=1 addr=8", imem_req_o, imem_addr_o);
        end
        set_idle();
    endtask

    task automatic test_redirect_drop();
        do_reset();
        rst_i      = 1'b0;
        imem_ack_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            imem_data_i = mem_word(32'(4 * i));
            tick();
        end
        imem_ack_i = 1'b0;
        tick();
        branch_taken_i  = 1'b1;
        branch_target_i = 32'h0000_0043;
        if_flush_i      = 1'b1;
        tick();
        branch_taken_i = 1'b0;
        if_flush_i     = 1'b0;
        n_compared++;
        if ({pc_o, imem_req_o, imem_addr_o, ifid_valid_o} !== {32'h40, 1'b1, 32'h10, 1'b0}) begin
            n_mismatched++;
            $display("[TB] FAIL redirect_enter_drop: got pc=%h req=%b addr=%h valid=%b expected pc=40 req=1 addr=10 valid=0", pc_o, imem_req_o, imem_addr_o, ifid_valid_o);
        end
        tick();
        n_compared++;
        if (imem_addr_o !== 32'h10) begin
            n_mismatched++;
            $display("[TB] FAIL redirect_addr_stable: got addr=%h expected addr=10", imem_addr_o);
        end
        imem_ack_i  = 1'b1;
        imem_data_i = 32'hDEAD_BEEF;
        tick();
        imem_ack_i = 1'b0;
        n_compared++;
        if ({ifid_valid_o, ifid_instr_o, imem_req_o, imem_addr_o} !== {1'b0, NOP, 1'b1, 32'h40}) begin
            n_mismatched++;
            $display("[TB] FAIL redirect_late_ack: got valid=%b instr=%h req=%b addr=%h expected valid=0 instr=%h req=1 addr=40", ifid_valid_o, ifid_instr_o, imem_req_o, imem_addr_o, NOP);
        end
        imem_ack_i  = 1'b1;
        imem_data_i = mem_word(32'h40);
        tick();
        n_compared++;
        if ({ifid_valid_o, ifid_instr_o, ifid_pc_plus4_o} !== {1'b1, mem_word(32'h40), 32'h44}) begin
            n_mismatched++;
            $display("[TB] FAIL redirect_target_fetch: got %b/%h/%h expected 1/%h/44", ifid_valid_o, ifid_instr_o, ifid_pc_plus4_o, mem_word(32'h40));
        end
        set_idle();
    endtask

    task automatic test_hold_flush();
        do_reset();
        rst_i       = 1'b0;
        imem_ack_i  = 1'b1;
        imem_data_i = mem_word(32'h0);
        tick();
        imem_ack_i  = 1'b0;
        pc_write_i  = 1'b0;
        ifid_hold_i = 1'b1;
        if_flush_i  = 1'b1;
        tick();
        n_compared++;
        if ({ifid_valid_o, ifid_instr_o, ifid_pc_plus4_o, pc_o} !== {1'b0, NOP, 32'h0, 32'h4}) begin
            n_mismatched++;
            $display("[TB] FAIL hold_flush: got ifid=%b/%h/%h pc=%h expected 0/%h/0 pc=4", ifid_valid_o, ifid_instr_o, ifid_pc_plus4_o, pc_o, NOP);
        end
        set_idle();
    endtask

    task automatic test_wrap();
        do_reset();
        rst_i           = 1'b0;
        branch_taken_i  = 1'b1;
        branch_target_i = 32'hFFFF_FFFF;
        if_flush_i      = 1'b1;
        imem_ack_i      = 1'b1;
        imem_data_i     = 32'hDEAD_BEEF;
        tick();
        set_idle();
        n_compared++;
        if ({pc_o, imem_req_o, imem_addr_o, ifid_valid_o} !== {32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC, 1'b0}) begin
            n_mismatched++;
            $display("[TB] FAIL wrap_redirect: got pc=%h req=%b addr=%h valid=%b expected pc=fffffffc req=1 addr=fffffffc valid=0", pc_o, imem_req_o, imem_addr_o, ifid_valid_o);
        end
        imem_ack_i  = 1'b1;
        imem_data_i = mem_word(32'hFFFF_FFFC);
        tick();
        n_compared++;
        if ({pc_o, ifid_valid_o, ifid_instr_o, ifid_pc_plus4_o} !== {32'h0, 1'b1, mem_word(32'hFFFF_FFFC), 32'h0}) begin
            n_mismatched++;
            $display("[TB] FAIL wrap_pc_plus4: got pc=%h ifid=%b/%h/%h expected pc=0 ifid=1/%h/0", pc_o, ifid_valid_o, ifid_instr_o, ifid_pc_plus4_o, mem_word(32'hFFFF_FFFC));
        end
        set_idle();
    endtask

    task automatic test_reset_mid_fetch();
        do_reset();
        rst_i       = 1'b0;
        imem_ack_i  = 1'b1;
        imem_data_i = mem_word(32'h0);
        tick();
        imem_ack_i  = 1'b0;
        pc_write_i  = 1'b0;
        ifid_hold_i = 1'b1;
        tick();
        tick();
        rst_i       = 1'b1;
        imem_ack_i  = 1'b1;
        imem_data_i = mem_word(32'h4);
        tick();
        set_idle();
        n_compared++;
        if ({pc_o, imem_req_o, ifid_valid_o, ifid_instr_o, ifid_pc_plus4_o} !== {RST_PC, 1'b0, 1'b0, NOP, 32'h0}) begin
            n_mismatched++;
            $display("[TB] FAIL reset_mid_fetch: got pc=%h req=%b ifid=%b/%h/%h expected pc=%h req=0 ifid=0/%h/0", pc_o, imem_req_o, ifid_valid_o, ifid_instr_o, ifid_pc_plus4_o, RST_PC, NOP);
        end
`ifdef FETCH_PERF_EN
        n_compared++;
        if ({perf_stall_cnt_o, perf_drop_cnt_o} !== 64'h0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_mid_fetch_perf: got %h/%h expected 0/0", perf_stall_cnt_o, perf_drop_cnt_o);
        end
`endif
        rst_i = 1'b0;
        #1;
        n_compared++;
        if ({imem_req_o, imem_addr_o} !== {1'b1, RST_PC}) begin
            n_mismatched++;
            $display("[TB] FAIL reset_mid_fetch_restart: got req=%b addr=%h expected req=1 addr=%h", imem_req_o, imem_addr_o, RST_PC);
        end
    endtask

    // Architectural model: IF/ID must present instructions in program order, where the
    // next expected PC advances by 4 per delivery and jumps to the target on a redirect.
    task automatic test_random();
        logic [31:0] exp_pc;
        logic [31:0] req_addr;
        logic [31:0] tgt;
        logic [64:0] prev_ifid;
        logic        stall;
        logic        br;
        logic        ack;
        logic        outstanding;
        int          waits;
        int          delivered;
        do_reset();
        rst_i       = 1'b0;
        exp_pc      = RST_PC;
        req_addr    = '0;
        outstanding = 1'b0;
        waits       = 0;
        delivered   = 0;
        for (int c = 0; c < 2000; c++) begin
            #1;
            stall = ($urandom_range(0, 3) == 0);
            br    = ($urandom_range(0, 9) == 0);
            tgt   = $urandom;
            if (imem_req_o) begin
                if (!outstanding) begin
                    outstanding = 1'b1;
                    waits       = $urandom_range(0, 2);
                    req_addr    = imem_addr_o;
                    n_compared++;
                    if (imem_addr_o !== exp_pc) begin
                        n_mismatched++;
                        $display("[TB] FAIL rand_new_req_addr[%0d]: got %h expected %h", c, imem_addr_o, exp_pc);
                    end
                end else begin
                    n_compared++;
                    if (imem_addr_o !== req_addr) begin
                        n_mismatched++;
                        $display("[TB] FAIL rand_addr_stable[%0d]: got %h expected %h", c, imem_addr_o, req_addr);
                    end
                end
            end
            ack             = imem_req_o && outstanding && (waits == 0);
            pc_write_i      = ~stall;
            ifid_hold_i     = stall;
            branch_taken_i  = br;
            if_flush_i      = br;
            branch_target_i = tgt;
            imem_ack_i      = ack;
            imem_data_i     = mem_word(req_addr);
            prev_ifid       = {ifid_valid_o, ifid_instr_o, ifid_pc_plus4_o};
            tick();
            if (ack) begin
                outstanding = 1'b0;
            end else if (outstanding) begin
                waits--;
            end
            n_compared++;
            if (br) begin
                exp_pc = tgt & 32'hFFFF_FFFC;
                if ({ifid_valid_o, ifid_instr_o, ifid_pc_plus4_o} !== {1'b0, NOP, 32'h0}) begin
                    n_mismatched++;
                    $display("[TB] FAIL rand_flush[%0d]: got %b/%h/%h expected bubble", c, ifid_valid_o, ifid_instr_o, ifid_pc_plus4_o);
                end
            end else if (stall) begin
                if ({ifid_valid_o, ifid_instr_o, ifid_pc_plus4_o} !== prev_ifid) begin
                    n_mismatched++;
                    $display("[TB] FAIL rand_hold[%0d]: got %b/%h/%h expected %h", c, ifid_valid_o, ifid_instr_o, ifid_pc_plus4_o, prev_ifid);
                end
            end else if (ifid_valid_o) begin
                if ({ifid_instr_o, ifid_pc_plus4_o} !== {mem_word(exp_pc), exp_pc + 32'd4}) begin
                    n_mismatched++;
                    $display("[TB] FAIL rand_deliver[%0d]: got %h/%h expected %h/%h", c, ifid_instr_o, ifid_pc_plus4_o, mem_word(exp_pc), exp_pc + 32'd4);
                end
                exp_pc = exp_pc + 32'd4;
                delivered++;
            end else begin
                if ({ifid_instr_o, ifid_pc_plus4_o} !== {NOP, 32'h0}) begin
                    n_mismatched++;
                    $display("[TB] FAIL rand_bubble[%0d]: got %h/%h expected %h/0", c, ifid_instr_o, ifid_pc_plus4_o, NOP);
                end
            end
            n_compared++;
            if (pc_o !== exp_pc) begin
                n_mismatched++;
                $display("[TB] FAIL rand_pc[%0d]: got %h expected %h", c, pc_o, exp_pc);
            end
        end
        set_idle();
        n_compared++;
        if (delivered < 100) begin
            n_mismatched++;
            $display("[TB] FAIL rand_progress: got %0d deliveries expected at least 100", delivered);
        end
    endtask

    initial begin
        #500_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_i = 1'b1;
        set_idle();
        test_reset();
        test_zero_wait();
        test_stall_buffer();
        test_redirect_drop();
        test_hold_flush();
        test_wrap();
        test_reset_mid_fetch();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
